// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg: shared definitions for the banked RISC-V data memory.
//   - size encodings for req_size
//   - FSM state enum (IDLE / SPLIT)
//   - size_bytes(): number of bytes touched by an access size
//   - lane_mask():  byte-lane enables across two consecutive words
//   - extend():     sign/zero extension of LSB-justified load data
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Illegal size touches nothing.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Bits [3:0] are lanes of the addressed word, bits [7:4] lanes of the
    // following word; any bit set in [7:4] means the access is split.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] offset);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << offset;
    endfunction

    // Word loads ignore is_unsigned.
    function automatic logic [31:0] extend(input logic [31:0] data,
                                           input logic [1:0]  size,
                                           input logic        is_unsigned);
        case (size)
            SZ_BYTE: return is_unsigned ? {24'b0, data[7:0]}
                                        : {{24{data[7]}}, data[7:0]};
            SZ_HALF: return is_unsigned ? {16'b0, data[15:0]}
                                        : {{16{data[15]}}, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if: request/response bus between the load/store unit and dmem_banked.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. The requester holds all req_* fields stable while
// req_valid is high. There is no response backpressure: resp_valid is a
// single-cycle pulse, and resp_rdata/resp_err are 0 whenever it is low.
//
// Signals:
//   req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata  (master out)
//   req_ready, resp_valid, resp_rdata, resp_err, busy               (slave out)
// -----------------------------------------------------------------------------
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_align.sv
// -----------------------------------------------------------------------------
// dmem_align: combinational load-data alignment.
// Concatenates the high and low beat words, shifts right by the byte offset
// and extends the LSB-justified result.
//   lo_word      in  32  word holding the first addressed byte
//   hi_word      in  32  following word (only used by split accesses)
//   offset       in  2   byte offset of the access within lo_word
//   size         in  2   access size encoding
//   is_unsigned  in  1   zero-extend when 1
//   data         out 32  extended load result
// -----------------------------------------------------------------------------
module dmem_align
    import dmem_pkg::*;
(
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [31:0] shifted;

    assign shifted = 32'({hi_word, lo_word} >> {offset, 3'b000});
    assign data    = extend(shifted, size, is_unsigned);
endmodule

// File: rtl/dmem_banked.sv
// -----------------------------------------------------------------------------
// dmem_banked: clocked byte-addressable data memory with valid/ready requests
// and registered responses. Accesses that cross a word boundary take two beats
// (IDLE -> SPLIT -> IDLE). Out-of-range addresses and size 11 respond with an
// error after one cycle and never touch storage.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   bus        slave side of dmem_if (request, response, busy)
//   dbg_state  out  current FSM state
// Storage is DEPTH_BYTES/4 words of four byte lanes, not cleared by reset.
// INIT_FILE is reserved for an integration-flow preload; empty means the
// contents start unknown.
// -----------------------------------------------------------------------------
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH_BYTES = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output state_t dbg_state
);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WAW   = AW - 2;
    localparam int WORDS = DEPTH_BYTES / 4;

    logic [31:0] mem [WORDS];

    state_t state, state_n;

    logic        resp_valid_q, resp_valid_n;
    logic [31:0] resp_rdata_q, resp_rdata_n;
    logic        resp_err_q,   resp_err_n;

    // Context carried from beat 1 into the SPLIT beat.
    logic [WAW-1:0] lat_word_q, lat_word_n;
    logic [1:0]     lat_off_q,  lat_off_n;
    logic [1:0]     lat_size_q, lat_size_n;
    logic           lat_uns_q,  lat_uns_n;
    logic           lat_we_q,   lat_we_n;
    logic [31:0]    lat_hi_data_q, lat_hi_data_n;
    logic [3:0]     lat_hi_mask_q, lat_hi_mask_n;
    logic [31:0]    lat_lo_q,   lat_lo_n;

    // Request decode.
    logic [2:0]     nbytes;
    logic [ADDR_W:0] last_byte;
    logic           req_err;
    logic [1:0]     off;
    logic [7:0]     mask;
    logic           crosses;
    logic [WAW-1:0] widx;
    logic [63:0]    wdata_sh;
    logic           accept;

    assign nbytes    = size_bytes(bus.req_size);
    // One bit wider than the address so the last touched byte cannot wrap to 0.
    assign last_byte = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    assign req_err   = (bus.req_size == SZ_ILL) ||
                       (last_byte >= (ADDR_W+1)'(DEPTH_BYTES));
    assign off       = bus.req_addr[1:0];
    assign mask      = lane_mask(bus.req_size, off);
    assign crosses   = |mask[7:4];
    assign widx      = bus.req_addr[AW-1:2];
    assign wdata_sh  = {32'b0, bus.req_wdata} << {off, 3'b000};
    assign accept    = bus.req_valid && bus.req_ready;

    // Single read port: the addressed word in IDLE, the second word in SPLIT.
    logic [WAW-1:0] rd_idx;
    logic [31:0]    rd_word;
    assign rd_idx  = (state == SPLIT) ? lat_word_q : widx;
    assign rd_word = mem[rd_idx];

    logic [31:0] al_lo, al_hi, al_out;
    logic [1:0]  al_off, al_size;
    logic        al_uns;
    assign al_lo   = (state == SPLIT) ? lat_lo_q   : rd_word;
    assign al_hi   = (state == SPLIT) ? rd_word    : 32'b0;
    assign al_off  = (state == SPLIT) ? lat_off_q  : off;
    assign al_size = (state == SPLIT) ? lat_size_q : bus.req_size;
    assign al_uns  = (state == SPLIT) ? lat_uns_q  : bus.req_unsigned;

    dmem_align u_align (
        .lo_word     (al_lo),
        .hi_word     (al_hi),
        .offset      (al_off),
        .size        (al_size),
        .is_unsigned (al_uns),
        .data        (al_out)
    );

    // Single write port.
    logic           wr_en;
    logic [WAW-1:0] wr_idx;
    logic [3:0]     wr_mask;
    logic [31:0]    wr_data;

    always_comb begin
        state_n       = state;
        resp_valid_n  = 1'b0;
        resp_rdata_n  = 32'b0;
        resp_err_n    = 1'b0;
        lat_word_n    = lat_word_q;
        lat_off_n     = lat_off_q;
        lat_size_n    = lat_size_q;
        lat_uns_n     = lat_uns_q;
        lat_we_n      = lat_we_q;
        lat_hi_data_n = lat_hi_data_q;
        lat_hi_mask_n = lat_hi_mask_q;
        lat_lo_n      = lat_lo_q;
        wr_en         = 1'b0;
        wr_idx        = widx;
        wr_mask       = mask[3:0];
        wr_data       = wdata_sh[31:0];

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        wr_en = bus.req_we;
                        if (crosses) begin
                            state_n       = SPLIT;
                            lat_word_n    = widx + WAW'(1);
                            lat_off_n     = off;
                            lat_size_n    = bus.req_size;
                            lat_uns_n     = bus.req_unsigned;
                            lat_we_n      = bus.req_we;
                            lat_hi_data_n = wdata_sh[63:32];
                            lat_hi_mask_n = mask[7:4];
                            lat_lo_n      = rd_word;
                        end else begin
                            resp_valid_n = 1'b1;
                            resp_rdata_n = bus.req_we ? 32'b0 : al_out;
                        end
                    end
                end
            end
            SPLIT: begin
                wr_en        = lat_we_q;
                wr_idx       = lat_word_q;
                wr_mask      = lat_hi_mask_q;
                wr_data      = lat_hi_data_q;
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_rdata_n = lat_we_q ? 32'b0 : al_out;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'b0;
            resp_err_q    <= 1'b0;
            lat_word_q    <= '0;
            lat_off_q     <= 2'b0;
            lat_size_q    <= 2'b0;
            lat_uns_q     <= 1'b0;
            lat_we_q      <= 1'b0;
            lat_hi_data_q <= 32'b0;
            lat_hi_mask_q <= 4'b0;
            lat_lo_q      <= 32'b0;
        end else begin
            state         <= state_n;
            resp_valid_q  <= resp_valid_n;
            resp_rdata_q  <= resp_rdata_n;
            resp_err_q    <= resp_err_n;
            lat_word_q    <= lat_word_n;
            lat_off_q     <= lat_off_n;
            lat_size_q    <= lat_size_n;
            lat_uns_q     <= lat_uns_n;
            lat_we_q      <= lat_we_n;
            lat_hi_data_q <= lat_hi_data_n;
            lat_hi_mask_q <= lat_hi_mask_n;
            lat_lo_q      <= lat_lo_n;
        end
    end

    // Storage has no reset; writes are suppressed while rst is asserted so a
    // request presented during reset cannot commit.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_mask[l]) mem[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state == SPLIT);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state;
endmodule
